dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller for the MEM stage of the 5-stage pipelined CPU. It sits between the EX/MEM pipeline register and the multi-cycle off-chip data memory. It replaces the single-cycle data memory path. On a miss it asserts `stall_o`, which freezes PC and all pipeline registers until the line is resident.

## Interface
Parameters:
- `LINES`, 16: number of cache lines (power of two); index width `IDX_W = log2(LINES)`.
- `LINE_BITS`, 256: line size, 32 bytes = 8 words; offset width 5.

Ports (name, direction, width, meaning):
- `clk_i`, in, 1: single clock; all state updates on rising edge.
- `rst_i`, in, 1: synchronous reset, active-high.
- `cpu_req_i`, in, 1: MEM-stage access valid; equals MemRead | MemWrite of EX/MEM.
- `cpu_we_i`, in, 1: 1 = store, 0 = load.
- `cpu_addr_i`, in, 32: byte address (ALU result); bits [1:0] ignored.
- `cpu_wdata_i`, in, 32: store data.
- `cpu_rdata_o`, out, 32: load data, valid when `cpu_req_i & ~cpu_we_i & ~stall_o`.
- `stall_o`, out, 1: pipeline freeze request.
- `mem_req_o`, out, 1: memory request, held until ack.
- `mem_we_o`, out, 1: 1 = line write-back, 0 = line fetch.
- `mem_addr_o`, out, 32: line-aligned address, bits [4:0] = 0.
- `mem_wdata_o`, out, 256: victim line data.
- `mem_ack_i`, in, 1: one-cycle completion pulse; carries read data on fetch.
- `mem_rdata_i`, in, 256: fetched line, sampled when `mem_ack_i` = 1 during fetch.

## Operation
- Address split with `LINES` = 16: word select = [4:2], index = [8:5], tag = [31:9] (23 bits). In general, tag = [31:5+IDX_W].
- Per line: valid, dirty, tag, 256-bit data.
- Hit = `cpu_req_i` & valid[idx] & (tag[idx] == addr tag). Hit is evaluated only in IDLE.
- FSM states: IDLE, WRITEBACK, ALLOCATE, REFILL.
- IDLE, hit, load: `cpu_rdata_o` = selected word, combinational; `stall_o` = 0.
- IDLE, hit, store: the selected word is replaced at the clock edge and dirty is set; `stall_o` = 0.
- IDLE, miss: `stall_o` = 1 in the same cycle, and `cpu_addr_i` is latched into `miss_addr`.
  - Victim dirty: go to WRITEBACK.
  - Victim clean or invalid: go to ALLOCATE.
- WRITEBACK: `mem_req_o` = 1, `mem_we_o` = 1, `mem_addr_o` = {victim tag, index, 5'b0}, `mem_wdata_o` = victim data. On `mem_ack_i`, go to ALLOCATE.
- ALLOCATE: `mem_req_o` = 1, `mem_we_o` = 0, `mem_addr_o` = {miss_addr[31:5], 5'b0}.
  - On `mem_ack_i`, write `mem_rdata_i` into the line, set valid = 1, dirty = 0, tag = miss tag.
  - Go to REFILL.
- REFILL: `stall_o` = 1 and no memory request. Go to IDLE, where the access is re-evaluated as a hit. A store then merges its data and sets dirty.
- All transactions use `miss_addr`, so the in-flight refill completes even if CPU inputs change while stalled. CPU inputs are stable under stall by construction.
- `mem_ack_i` is ignored in IDLE and REFILL.
- `mem_wdata_o` is 0 when not in WRITEBACK. `mem_addr_o` is 0 in IDLE and REFILL.

## Timing
- Reset values:
  - State = IDLE.
  - All valid and dirty bits = 0; tags and data are don't-care.
  - `mem_req_o` = 0, `mem_we_o` = 0, `mem_addr_o` = 0, `mem_wdata_o` = 0.
  - `stall_o` = 0; it may assert combinationally from `cpu_req_i` on the first post-reset cycle.
  - `cpu_rdata_o` = 0 while `cpu_req_i` = 0.
- Hit latency: 0 extra cycles.
- Clean miss with memory ack latency L (ack in the L-th cycle of the request): stall cycles = 1 (IDLE) + L + 1 (REFILL).
- Dirty miss: the clean-miss figure plus L.
- Memory handshake:
  - `mem_req_o` and all `mem_*` outputs are stable from assertion until the cycle `mem_ack_i` = 1.
  - `mem_req_o` falls the cycle after the ack.
  - An ack coinciding with the first request cycle (L = 1) is legal.
- Reset mid-transaction: the FSM returns to IDLE at that edge and `mem_req_o` = 0 the next cycle. The memory model must drop an outstanding request when `mem_req_o` falls without an ack. All lines are invalidated.
- `cpu_req_i` = 0 in IDLE: no state change, `stall_o` = 0.

## Structure
- Package `dcache_pkg` holds:
  - the state enum (IDLE, WRITEBACK, ALLOCATE, REFILL);
  - the `LINE_BITS`, `OFFSET_W` and `WORD_SEL_W` constants;
  - tag/index extraction functions.
- Sub-module `dcache_sram` holds the valid/dirty/tag/data arrays. It has:
  - an index-addressed combinational read;
  - synchronous line write (refill) and word write with dirty set (store hit);
  - synchronous clear of valid and dirty on `rst_i`.
- `dcache_ctrl` holds the FSM, `miss_addr`, hit logic and memory-side muxing.

## Test plan
- Reset, then load 0x0000_0040 with memory word = 0x1234_5678 and L = 10:
  - `stall_o` high for 12 cycles;
  - one fetch at `mem_addr_o` = 0x40;
  - `cpu_rdata_o` = 0x1234_5678.
- Repeat the load at 0x44 immediately: 0 stall cycles, no `mem_req_o`.
- Store 0xDEAD_BEEF to 0x40 (hit), then load 0x240 (same index, different tag):
  - a WRITEBACK to 0x40 whose line word 0 = 0xDEAD_BEEF;
  - then a fetch to 0x240;
  - stall = 1 + 2L + 1 cycles.
- Store miss to 0x1000 (clean victim):
  - fetch only, then the word is merged;
  - a subsequent load of 0x1000 returns the stored value, and the line is dirty (checked via a later eviction write-back).
- L = 1 ack on the first request cycle: the FSM advances correctly and `mem_req_o` drops the next cycle.
- `rst_i` pulsed during ALLOCATE: `mem_req_o` = 0 the cycle after reset, and a reload of the same address misses again.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types, line geometry and address-field helpers for the data cache.
package dcache_pkg;

    localparam int LINE_BITS  = 256;
    localparam int OFFSET_W   = 5;
    localparam int WORD_SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        REFILL
    } state_e;

    // Line index of a byte address, right-aligned; callers cast to IDX_W bits.
    function automatic logic [31:0] index_of(input logic [31:0] addr, input int idx_w);
        return (addr >> OFFSET_W) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    // Tag of a byte address, right-aligned; callers cast to TAG_W bits.
    function automatic logic [31:0] tag_of(input logic [31:0] addr, input int idx_w);
        return addr >> (OFFSET_W + idx_w);
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Valid/dirty/tag/data storage for the direct-mapped cache, one entry per line.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 32 - OFFSET_W - IDX_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IDX_W-1:0]      idx_i,
    output logic                  valid_o,
    output logic                  dirty_o,
    output logic [TAG_W-1:0]      tag_o,
    output logic [LINE_BITS-1:0]  data_o,
    input  logic                  line_we_i,
    input  logic [TAG_W-1:0]      line_tag_i,
    input  logic [LINE_BITS-1:0]  line_data_i,
    input  logic                  word_we_i,
    input  logic [WORD_SEL_W-1:0] word_sel_i,
    input  logic [31:0]           word_data_i
);

    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     dirty_q;
    logic [TAG_W-1:0]     tag_q  [LINES];
    logic [LINE_BITS-1:0] data_q [LINES];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign data_o  = data_q[idx_i];

    // Line status: cleared on reset, set valid/clean on refill, dirty on store hit.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Tag and data storage: whole-line refill or single-word store merge.
    // NOTE: the tag/data arrays have no reset; a cleared valid bit makes their contents irrelevant.
    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            tag_q[idx_i]  <= line_tag_i;
            data_q[idx_i] <= line_data_i;
        end else if (word_we_i) begin
            data_q[idx_i][32*word_sel_i +: 32] <= word_data_i;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller for the MEM stage.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_wdata_i,
    output logic [31:0]          cpu_rdata_o,
    output logic                 stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_wdata_o,
    input  logic                 mem_ack_i,
    input  logic [LINE_BITS-1:0] mem_rdata_i
);

    localparam int IDX_W       = $clog2(LINES);
    localparam int TAG_W       = 32 - OFFSET_W - IDX_W;
    localparam int LINE_ADDR_W = 32 - OFFSET_W;

    state_e                 state_q, state_d;
    logic [LINE_ADDR_W-1:0] miss_line_q, miss_line_d;

    logic [31:0]            miss_addr;
    logic [IDX_W-1:0]       cpu_idx, miss_idx, sram_idx;
    logic [TAG_W-1:0]       cpu_tag, miss_tag;
    logic [WORD_SEL_W-1:0]  word_sel;
    logic                   sram_valid, sram_dirty;
    logic [TAG_W-1:0]       sram_tag;
    logic [LINE_BITS-1:0]   sram_data;
    logic                   hit, miss;
    logic                   line_we, word_we;
    logic                   unused_byte_sel;

    // Byte lanes within a word are not used by a word-wide cache.
    assign unused_byte_sel = ^cpu_addr_i[1:0];

    assign miss_addr = {miss_line_q, {OFFSET_W{1'b0}}};
    assign cpu_idx   = IDX_W'(index_of(cpu_addr_i, IDX_W));
    assign cpu_tag   = TAG_W'(tag_of(cpu_addr_i, IDX_W));
    assign miss_idx  = IDX_W'(index_of(miss_addr, IDX_W));
    assign miss_tag  = TAG_W'(tag_of(miss_addr, IDX_W));
    assign word_sel  = cpu_addr_i[OFFSET_W-1:2];

    // The live CPU address drives the arrays only while idle; the latched miss
    // address owns them for the rest of the transaction.
    assign sram_idx = (state_q == IDLE) ? cpu_idx : miss_idx;

    assign hit  = (state_q == IDLE) && cpu_req_i && sram_valid && (sram_tag == cpu_tag);
    assign miss = (state_q == IDLE) && cpu_req_i && !hit;

    dcache_sram #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (sram_idx),
        .valid_o     (sram_valid),
        .dirty_o     (sram_dirty),
        .tag_o       (sram_tag),
        .data_o      (sram_data),
        .line_we_i   (line_we),
        .line_tag_i  (miss_tag),
        .line_data_i (mem_rdata_i),
        .word_we_i   (word_we),
        .word_sel_i  (word_sel),
        .word_data_i (cpu_wdata_i)
    );

    // State and miss-address registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            miss_line_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_line_q <= miss_line_d;
        end
    end

    // Next state: miss picks write-back or allocate from the victim's dirty bit.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        miss_line_d = miss_line_q;
        case (state_q)
            IDLE: begin
                if (miss) begin
                    miss_line_d = cpu_addr_i[31:OFFSET_W];
                    state_d     = (sram_valid && sram_dirty) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: if (mem_ack_i) state_d = ALLOCATE;
            ALLOCATE:  if (mem_ack_i) state_d = REFILL;
            REFILL:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs: CPU-side hit path in IDLE, memory handshake in WRITEBACK/ALLOCATE.
    always_comb begin
        stall_o     = 1'b1;
        cpu_rdata_o = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        line_we     = 1'b0;
        word_we     = 1'b0;
        case (state_q)
            IDLE: begin
                stall_o = miss;
                word_we = hit && cpu_we_i;
                if (hit && !cpu_we_i) begin
                    cpu_rdata_o = sram_data[32*word_sel +: 32];
                end
            end
            WRITEBACK: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {sram_tag, miss_idx, {OFFSET_W{1'b0}}};
                mem_wdata_o = sram_data;
            end
            ALLOCATE: begin
                mem_req_o  = 1'b1;
                mem_addr_o = miss_addr;
                line_we    = mem_ack_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed vector table, multi-cycle
// corner sequences, then random accesses against a flat-memory reference model.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i, cpu_we_i;
    logic [31:0]  cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
    logic         stall_o;
    logic         mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o, mem_rdata_i;

    dcache_ctrl #(.LINES(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    initial forever #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [255:0] backing [logic [26:0]];   // off-chip memory, by line address
    logic [31:0]  ref_mem [logic [29:0]];   // CPU-visible stores not yet in backing
    bit           m_valid [16];
    bit           m_dirty [16];
    logic [22:0]  m_tag   [16];
    int           mem_lat = 10;
    bit           mem_on  = 1'b0;
    int           proto_err = 0;

    typedef struct {
        logic [31:0]  addr;
        logic [255:0] data;
    } wb_t;
    wb_t         wb_q[$];
    logic [31:0] fetch_q[$];

    function automatic logic [31:0] default_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [255:0] backing_line(input logic [26:0] la);
        logic [255:0] l;
        if (backing.exists(la)) return backing[la];
        for (int i = 0; i < 8; i++) begin
            logic [2:0] w = 3'(i);
            l[32*i +: 32] = default_word({la, w, 2'b00});
        end
        return l;
    endfunction

    function automatic logic [31:0] ref_view(input logic [31:0] a);
        logic [255:0] l;
        if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
        l = backing_line(a[31:5]);
        return l[32*a[4:2] +: 32];
    endfunction

    // Stall prediction from the miss-cost rules, then update residency and CPU view.
    function automatic int model_access(input bit we, input logic [31:0] a, input logic [31:0] wd);
        int          st = 0;
        logic [3:0]  ix = a[8:5];
        logic [22:0] tg = a[31:9];
        if (!(m_valid[ix] && m_tag[ix] == tg)) begin
            st = 1 + mem_lat + 1 + ((m_valid[ix] && m_dirty[ix]) ? mem_lat : 0);
            m_valid[ix] = 1'b1;
            m_tag[ix]   = tg;
            m_dirty[ix] = 1'b0;
        end
        if (we) begin
            m_dirty[ix]     = 1'b1;
            ref_mem[a[31:2]] = wd;
        end
        return st;
    endfunction

    // ---------------- memory responder ----------------
    initial begin
        int           cnt = 0;
        logic [31:0]  s_addr;
        logic         s_we;
        logic [255:0] s_wd;
        logic [255:0] exp_line;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            mem_ack_i   = 1'b0;
            mem_rdata_i = {8{32'hBAD0_BAD0}};
            if (mem_on) begin
                if (!mem_req_o) begin
                    cnt = 0;
                    if (mem_addr_o !== 32'd0 || mem_wdata_o !== '0 || mem_we_o !== 1'b0) proto_err++;
                end else begin
                    cnt++;
                    if (cnt == 1) begin
                        s_addr = mem_addr_o; s_we = mem_we_o; s_wd = mem_wdata_o;
                    end else if (mem_addr_o !== s_addr || mem_we_o !== s_we || mem_wdata_o !== s_wd) begin
                        proto_err++;
                    end
                    if (mem_addr_o[4:0] !== 5'd0) proto_err++;
                    if (!mem_we_o && mem_wdata_o !== '0) proto_err++;
                    if (cnt >= mem_lat && !rst_i) begin
                        mem_ack_i = 1'b1;
                        cnt = 0;
                        if (mem_we_o) begin
                            for (int i = 0; i < 8; i++)
                                exp_line[32*i +: 32] = ref_view(mem_addr_o + 32'(4*i));
                            check("writeback line", mem_wdata_o, exp_line);
                            wb_q.push_back('{mem_addr_o, mem_wdata_o});
                            backing[mem_addr_o[31:5]] = mem_wdata_o;
                        end else begin
                            fetch_q.push_back(mem_addr_o);
                            mem_rdata_i = backing_line(mem_addr_o[31:5]);
                        end
                    end
                end
            end
        end
    end

    // ---------------- CPU access driver ----------------
    // Called just after a rising edge; returns just after the edge that completes the access.
    task automatic do_access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                             input int exp_stall, input logic [31:0] exp_rd, input string name);
        int stalls = 0;
        bit done   = 1'b0;
        cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_wdata_i = wd;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk_i);
            if (stall_o) stalls++;
            else begin
                done = 1'b1;
                if (!we) check({name, " rdata"}, cpu_rdata_o, exp_rd);
            end
            @(posedge clk_i);
            #1;
        end
        cpu_req_i = 1'b0;
        if (!done) check({name, " timeout"}, 0, 1);
        check({name, " stalls"}, stalls, exp_stall);
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stalls;
        logic [31:0] rdata;
        bit          wb;
        logic [31:0] wb_addr;
        logic [31:0] wb_word0;
        bit          fetch;
        logic [31:0] fetch_addr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] l;
        logic [3:0]   req_tr, st_tr;
        logic [31:0]  a, wd, exp_rd;
        logic [22:0]  tg;
        bit           we;
        int           st;

        vecs[0] = '{0, 32'h0000_0040, 32'h0,         12, 32'h1234_5678, 0, 32'h0,    32'h0,         1, 32'h40};
        vecs[1] = '{0, 32'h0000_0044, 32'h0,          0, 32'h0044_FFBB, 0, 32'h0,    32'h0,         0, 32'h0};
        vecs[2] = '{1, 32'h0000_0040, 32'hDEAD_BEEF,  0, 32'h0,         0, 32'h0,    32'h0,         0, 32'h0};
        vecs[3] = '{0, 32'h0000_0240, 32'h0,         22, 32'h0240_FDBF, 1, 32'h40,   32'hDEAD_BEEF, 1, 32'h240};
        vecs[4] = '{1, 32'h0000_1000, 32'hCAFE_F00D, 12, 32'h0,         0, 32'h0,    32'h0,         1, 32'h1000};
        vecs[5] = '{0, 32'h0000_1000, 32'h0,          0, 32'hCAFE_F00D, 0, 32'h0,    32'h0,         0, 32'h0};
        vecs[6] = '{0, 32'h0000_3000, 32'h0,         22, 32'h3000_CFFF, 1, 32'h1000, 32'hCAFE_F00D, 1, 32'h3000};

        l = backing_line(27'h2);
        l[31:0] = 32'h1234_5678;
        backing[27'h2] = l;

        rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("reset stall",     stall_o,     0);
        check("reset mem_req",   mem_req_o,   0);
        check("reset mem_we",    mem_we_o,    0);
        check("reset mem_addr",  mem_addr_o,  0);
        check("reset mem_wdata", mem_wdata_o, 0);
        check("reset rdata",     cpu_rdata_o, 0);
        mem_on = 1'b1;
        @(posedge clk_i);
        #1;

        // Directed vector table, memory latency 10.
        for (int i = 0; i < 7; i++) begin
            wb_q.delete();
            fetch_q.delete();
            do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].stalls, vecs[i].rdata,
                      $sformatf("vec%0d", i));
            st = model_access(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d wb count", i), wb_q.size(), vecs[i].wb);
            if (vecs[i].wb && wb_q.size() > 0) begin
                check($sformatf("vec%0d wb addr", i),  wb_q[0].addr,       vecs[i].wb_addr);
                check($sformatf("vec%0d wb word0", i), wb_q[0].data[31:0], vecs[i].wb_word0);
            end
            check($sformatf("vec%0d fetch count", i), fetch_q.size(), vecs[i].fetch);
            if (vecs[i].fetch && fetch_q.size() > 0)
                check($sformatf("vec%0d fetch addr", i), fetch_q[0], vecs[i].fetch_addr);
        end

        // L = 1: ack on the first request cycle, request drops the next cycle.
        mem_lat = 1;
        fetch_q.delete();
        exp_rd = ref_view(32'h4000);
        st = model_access(1'b0, 32'h4000, 32'h0);
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h4000;
        req_tr = '0; st_tr = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            req_tr[c] = mem_req_o;
            st_tr[c]  = stall_o;
            if (c == 3) check("L1 rdata", cpu_rdata_o, exp_rd);
            @(posedge clk_i);
            #1;
        end
        cpu_req_i = 1'b0;
        check("L1 req trace",   req_tr, 4'b0010);
        check("L1 stall trace", st_tr,  4'b0111);
        check("L1 fetch count", fetch_q.size(), 1);

        // Reset pulsed mid-ALLOCATE: request drops, all lines invalidated.
        mem_lat = 10;
        fetch_q.delete();
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h5000;
        repeat (4) @(posedge clk_i);
        #1;
        check("pre-reset req", mem_req_o, 1);
        rst_i = 1'b1;
        cpu_req_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post-reset req",   mem_req_o, 0);
        check("post-reset stall", stall_o,   0);
        check("post-reset fetch", fetch_q.size(), 0);
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        ref_mem.delete();
        @(posedge clk_i);
        #1;
        exp_rd = ref_view(32'h5000);
        st = model_access(1'b0, 32'h5000, 32'h0);
        do_access(1'b0, 32'h5000, 32'h0, st, exp_rd, "reload after reset");
        // Previously resident line must also miss again.
        exp_rd = ref_view(32'h0240);
        st = model_access(1'b0, 32'h0240, 32'h0);
        do_access(1'b0, 32'h0240, 32'h0, st, exp_rd, "reload 0x240");

        // Random accesses over a few tags and indices, latency 1..4.
        for (int n = 0; n < 300; n++) begin
            mem_lat = $urandom_range(1, 4);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk_i);
                check("idle stall", stall_o, 0);
                @(posedge clk_i);
                #1;
            end
            case ($urandom_range(0, 3))
                0: tg = 23'h0;
                1: tg = 23'h1;
                2: tg = 23'h2;
                default: tg = 23'h7F_FFFF;
            endcase
            a  = {tg, 4'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            exp_rd = ref_view(a);
            st = model_access(we, a, wd);
            do_access(we, a, wd, st, exp_rd, $sformatf("rand%0d", n));
        end

        check("memory protocol", proto_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
